m_imem_loader: RTL and testbench

Serial boot loader that receives a program over an 8N1 UART line and writes it, word by word, into instruction memory through the same 12-bit-address, 32-bit-data write port the data memory uses. It holds the processor in reset until the image is fully loaded. It sits between the board's UART RX pin and the write side of `m_imem`, with its `r_proc_rst` output gating the processor's reset.

---
 rtl/loader_pkg.sv | 30 +++
 rtl/m_uart_rx.sv | 121 ++++++++++++
 rtl/m_imem_loader.sv | 165 ++++++++++++++++
 tb/tb_m_imem_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the serial instruction-memory boot loader:
//   - loader_st_e      : 3-bit loader FSM state encoding
//   - CNT_BYTES        : bytes in the little-endian word-count header
//   - WORD_BYTES       : bytes per payload word (sent MSB first)
//   - DEF_CLKS_PER_BIT : default UART bit period (50 MHz / 115200)
//   - csum_upd()       : running XOR checksum step
// -----------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CNT1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_st_e;

  localparam int CNT_BYTES        = 2;
  localparam int WORD_BYTES       = 4;
  localparam int DEF_CLKS_PER_BIT = 434;

  // One step of the frame checksum: XOR of every count and payload byte.
  function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/m_uart_rx.sv
// -----------------------------------------------------------------------------
// m_uart_rx
// 8N1 UART receiver with a 2-flop input synchronizer.
// Ports:
//   w_clk   in  system clock
//   w_rst_n in  asynchronous active-low reset
//   w_rxd   in  asynchronous serial line, idles high
//   r_byte  out received byte, valid while r_vld is high
//   r_vld   out one-cycle pulse, one cycle after a good stop-bit sample
//   r_ferr  out one-cycle pulse when the stop bit samples low
// A falling edge starts the bit timer; the start bit is re-checked at half a
// bit so short low glitches are discarded without delivering a byte.
// -----------------------------------------------------------------------------
module m_uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic       w_rxd,
  output logic [7:0] r_byte,
  output logic       r_vld,
  output logic       r_ferr
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_st_e;

  rx_st_e           st_r;
  logic             rxd_meta_r;
  logic             rxd_sync_r;
  logic             rxd_prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_r;
  logic [7:0]       shift_r;

  // Synchronize the raw line and keep one delayed copy for edge detection.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= w_rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // Bit timing and deserialization; edges seen outside IDLE are ignored.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      st_r    <= RX_IDLE;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      r_byte  <= 8'h00;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_ferr <= 1'b0;
      case (st_r)
        RX_IDLE: begin
          cnt_r <= '0;
          bit_r <= 3'd0;
          if (rxd_prev_r && !rxd_sync_r) begin
            st_r <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_r == HALF_C) begin
            cnt_r <= '0;
            // Line back high at mid-start: a glitch, not a character.
            st_r  <= rxd_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (cnt_r == FULL_C) begin
            cnt_r   <= '0;
            shift_r <= {rxd_sync_r, shift_r[7:1]};
            bit_r   <= bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              st_r <= RX_STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (cnt_r == FULL_C) begin
            cnt_r <= '0;
            st_r  <= RX_IDLE;
            if (rxd_sync_r) begin
              r_byte <= shift_r;
              r_vld  <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: st_r <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/m_imem_loader.sv
// -----------------------------------------------------------------------------
// m_imem_loader
// UART boot loader: receives "count(2 bytes, LE) + N words (4 bytes, MSB
// first) [+ XOR checksum]" and writes the words to instruction memory starting
// at address 0, holding the processor in reset until the image is complete.
// Ports:
//   w_clk, w_rst_n         clock, asynchronous active-low reset
//   w_rxd                  UART receive line
//   r_we/r_addr/r_wdata    one-cycle instruction-memory write port
//   r_proc_rst             processor reset, released only in DONE
//   r_busy                 header received, image not yet complete
//   r_done, r_err          sticky completion / error flags
// Build option: define LOADER_CHECKSUM_EN to expect a trailing checksum byte.
// -----------------------------------------------------------------------------
module m_imem_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int ADDR_W       = 12
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  output logic              r_proc_rst,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_st_e END_ST = ST_CSUM;
`else
  localparam loader_st_e END_ST = ST_DONE;
`endif
  // Whether finishing the payload lands directly in DONE.
  localparam logic              END_IS_DONE = (END_ST == ST_DONE) ? 1'b1 : 1'b0;
  localparam logic [ADDR_W-1:0] ADDR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]        LAST_IDX    = 2'(WORD_BYTES - 1);

  logic [7:0]  rx_byte_s;
  logic        rx_vld_s;
  logic        rx_ferr_s;
  loader_st_e  st_r;
  logic [7:0]  cnt_lo_r;
  logic [15:0] words_left_r;
  logic [1:0]  idx_r;

  m_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .w_clk  (w_clk),
    .w_rst_n(w_rst_n),
    .w_rxd  (w_rxd),
    .r_byte (rx_byte_s),
    .r_vld  (rx_vld_s),
    .r_ferr (rx_ferr_s)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_r;

  // Running XOR over every count and payload byte of the frame.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      csum_r <= 8'h00;
    end else if (rx_vld_s && ((st_r == ST_IDLE) || (st_r == ST_CNT1) || (st_r == ST_DATA))) begin
      csum_r <= csum_upd(csum_r, rx_byte_s);
    end
  end
`endif

  // Loader FSM with word assembly, address/word counters and status outputs.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      st_r         <= ST_IDLE;
      cnt_lo_r     <= 8'h00;
      words_left_r <= 16'h0000;
      idx_r        <= 2'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'h0000_0000;
      r_proc_rst   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (rx_ferr_s && (st_r != ST_DONE) && (st_r != ST_ERR)) begin
        st_r   <= ST_ERR;
        r_busy <= 1'b0;
        r_err  <= 1'b1;
      end else begin
        case (st_r)
          ST_IDLE: begin
            if (rx_vld_s) begin
              cnt_lo_r <= rx_byte_s;
              st_r     <= ST_CNT1;
              r_busy   <= 1'b1;
            end
          end
          ST_CNT1: begin
            if (rx_vld_s) begin
              words_left_r <= {rx_byte_s, cnt_lo_r};
              idx_r        <= 2'd0;
              if ({rx_byte_s, cnt_lo_r} == 16'h0000) begin
                st_r       <= END_ST;
                r_busy     <= ~END_IS_DONE;
                r_done     <= END_IS_DONE;
                r_proc_rst <= ~END_IS_DONE;
              end else begin
                st_r <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            // The write cycle advances the address; the next byte is at least
            // a full character away, so it never collides with this step.
            if (r_we) begin
              r_addr <= r_addr + ADDR_ONE;
              if (words_left_r == 16'h0000) begin
                st_r       <= END_ST;
                r_busy     <= ~END_IS_DONE;
                r_done     <= END_IS_DONE;
                r_proc_rst <= ~END_IS_DONE;
              end
            end else if (rx_vld_s) begin
              r_wdata <= {r_wdata[23:0], rx_byte_s};
              idx_r   <= idx_r + 2'd1;
              if (idx_r == LAST_IDX) begin
                r_we         <= 1'b1;
                words_left_r <= words_left_r - 16'd1;
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CSUM: begin
            if (rx_vld_s) begin
              r_busy <= 1'b0;
              if (rx_byte_s == csum_r) begin
                st_r       <= ST_DONE;
                r_done     <= 1'b1;
                r_proc_rst <= 1'b0;
              end else begin
                st_r  <= ST_ERR;
                r_err <= 1'b1;
              end
            end
          end
`endif
          ST_DONE: st_r <= ST_DONE;
          ST_ERR:  st_r <= ST_ERR;
          default: begin
            st_r   <= ST_ERR;
            r_busy <= 1'b0;
            r_err  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_m_imem_loader
// Randomized frames are serialized onto w_rxd; the expected memory writes are
// queued from the frame contents and a negedge monitor pops and compares each
// write strobe. End-of-frame status is derived from the frame rules.
// -----------------------------------------------------------------------------
module tb_m_imem_loader;

  localparam int CPB = 16;
  localparam int AW  = 12;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          w_clk   = 1'b0;
  logic          w_rst_n = 1'b0;
  logic          w_rxd   = 1'b1;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_proc_rst;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int done_rise_cyc = -1;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    words[$];

  m_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .w_rxd     (w_rxd),
    .r_we      (r_we),
    .r_addr    (r_addr),
    .r_wdata   (r_wdata),
    .r_proc_rst(r_proc_rst),
    .r_busy    (r_busy),
    .r_done    (r_done),
    .r_err     (r_err)
  );

  always #5 w_clk = ~w_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  initial begin
    logic [AW+31:0] e;
    logic prev_we;
    logic prev_done;
    prev_we = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge w_clk);
      cyc++;
      if (w_rst_n) begin
        if (r_we) begin
          check("we_single_cycle", {63'd0, prev_we}, 64'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", r_addr, r_wdata);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", {52'd0, r_addr}, {52'd0, e[AW+31:32]});
            check("wr_data", {32'd0, r_wdata}, {32'd0, e[31:0]});
          end
          last_we_cyc = cyc;
        end
        if (r_done && !prev_done) done_rise_cyc = cyc;
      end
      prev_we = r_we;
      prev_done = r_done;
    end
  end

  task automatic send_bit(input logic b);
    w_rxd = b;
    repeat (CPB) @(negedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    if (!stop) send_bit(1'b1);
    send_bit(1'b1);
  endtask

  // Build a frame from 'words', send it and queue the writes it should cause.
  // bad_stop_at: byte index sent with a low stop bit (-1 none);
  // cut_after: stop after this many bytes (-1 send all).
  task automatic send_frame(input int n, input int bad_stop_at, input bit bad_csum,
                            input int cut_after, output bit exp_err);
    logic [7:0] bytes[$];
    logic [7:0] cs;
    bit err;
    int w;
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    for (int wi = 0; wi < n; wi++)
      for (int j = 3; j >= 0; j--) bytes.push_back(words[wi][8*j +: 8]);
    cs = 8'h00;
    foreach (bytes[k]) cs = cs ^ bytes[k];
    if (CS_EN) bytes.push_back(bad_csum ? (cs ^ 8'h01) : cs);
    err = 1'b0;
    for (int k = 0; k < bytes.size(); k++) begin
      if (cut_after >= 0 && k >= cut_after) break;
      if (k == bad_stop_at) err = 1'b1;
      if (!err && k >= 2 && k < 2 + 4*n && ((k - 2) % 4) == 3) begin
        w = (k - 2) / 4;
        exp_q.push_back({AW'(w), words[w]});
      end
      send_byte(bytes[k], (k != bad_stop_at));
    end
    exp_err = err | (CS_EN & bad_csum);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},       {63'd0, r_we},       64'd0);
    check({tag, "_addr"},     {52'd0, r_addr},     64'd0);
    check({tag, "_wdata"},    {32'd0, r_wdata},    64'd0);
    check({tag, "_proc_rst"}, {63'd0, r_proc_rst}, 64'd1);
    check({tag, "_busy"},     {63'd0, r_busy},     64'd0);
    check({tag, "_done"},     {63'd0, r_done},     64'd0);
    check({tag, "_err"},      {63'd0, r_err},      64'd0);
  endtask

  task automatic check_end(input string tag, input bit exp_err, input int n);
    repeat (4) @(negedge w_clk);
    check({tag, "_done"},     {63'd0, r_done},     {63'd0, ~exp_err});
    check({tag, "_err"},      {63'd0, r_err},      {63'd0, exp_err});
    check({tag, "_proc_rst"}, {63'd0, r_proc_rst}, {63'd0, exp_err});
    check({tag, "_busy"},     {63'd0, r_busy},     64'd0);
    check({tag, "_pending"},  64'(exp_q.size()),   64'd0);
    if (!exp_err && !CS_EN && n > 0)
      check({tag, "_done_lat"}, 64'(done_rise_cyc - last_we_cyc), 64'd1);
  endtask

  task automatic do_reset();
    w_rst_n = 1'b0;
    w_rxd = 1'b1;
    repeat (3) @(negedge w_clk);
    exp_q.delete();
    last_we_cyc = -1;
    done_rise_cyc = -1;
    w_rst_n = 1'b1;
    repeat (2*CPB) @(negedge w_clk);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom());
  endtask

  initial begin
    bit e;
    int n;
    repeat (3) @(negedge w_clk);
    check_reset_vals("rst");
    w_rst_n = 1'b1;
    repeat (2*CPB) @(negedge w_clk);

    // Directed two-word image.
    words.delete();
    words.push_back(32'h2001_0020);
    words.push_back(32'h0000_0000);
    send_frame(2, -1, 1'b0, -1, e);
    check_end("n2", e, 2);

    // Empty image.
    do_reset();
    words.delete();
    send_frame(0, -1, 1'b0, -1, e);
    check_end("n0", e, 0);

    // Framing error on the first byte of the second word; later bytes ignored.
    do_reset();
    rand_words(2);
    send_frame(2, 6, 1'b0, -1, e);
    check_end("ferr", e, 2);

    // Short low glitch: nothing received, then a normal load.
    do_reset();
    w_rxd = 1'b0;
    repeat (CPB*3/10) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (3*CPB) @(negedge w_clk);
    check("glitch_busy", {63'd0, r_busy}, 64'd0);
    check("glitch_err",  {63'd0, r_err},  64'd0);
    check("glitch_prst", {63'd0, r_proc_rst}, 64'd1);
    rand_words(3);
    send_frame(3, -1, 1'b0, -1, e);
    check_end("glitch_load", e, 3);

    // Reset after 5 of 8 payload bytes, then a full reload from address 0.
    do_reset();
    rand_words(2);
    send_frame(2, -1, 1'b0, 7, e);
    check("mid_pending", 64'(exp_q.size()), 64'd0);
    w_rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    do_reset();
    send_frame(2, -1, 1'b0, -1, e);
    check_end("reload", e, 2);

    if (CS_EN) begin
      do_reset();
      words.delete();
      words.push_back(32'h8C0C_0000);
      send_frame(1, -1, 1'b0, -1, e);
      check("cs_good_expect", {63'd0, e}, 64'd0);
      check_end("cs_good", e, 1);
      do_reset();
      send_frame(1, -1, 1'b1, -1, e);
      check_end("cs_bad", e, 1);
    end

    // Randomized frames.
    for (int t = 0; t < 5; t++) begin
      do_reset();
      n = $urandom_range(1, 5);
      rand_words(n);
      send_frame(n, ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 1 + 4*n)) : -1,
                 ($urandom_range(0, 2) == 0), -1, e);
      check_end($sformatf("rnd%0d", t), e, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
